// File: rtl/axi4_master_pkg.sv
// Shared types and constants for the AXI4 INCR-burst master.
package axi4_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_ERR
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  function automatic logic [2:0] size_from_width(input int unsigned width);
    case (width)
      8:       return 3'd0;
      16:      return 3'd1;
      32:      return 3'd2;
      64:      return 3'd3;
      default: return 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/axi4_w_hold.sv
// One-entry W-channel holding register: VALID stays up until READY,
// independent of how the producer drives its own valid.
module axi4_w_hold #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_enable,
  input  logic                  i_data_valid,
  output logic                  o_data_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_load;

  assign o_data_ready = i_enable && (!r_valid || i_ready);
  assign w_load       = i_data_valid && o_data_ready;
  assign o_valid      = r_valid;
  assign o_data       = r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axi4_burst_master.sv
// AXI4 INCR-burst master: command port plus write/read data streams in,
// single outstanding AW/W/B or AR/R transaction out, with completion status.
module axi4_burst_master
  import axi4_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic                    wr_data_valid,
  output logic                    wr_data_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    rd_data_valid,
  input  logic                    rd_data_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    done_valid,
  output logic [1:0]              done_resp,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic [7:0]              AWLEN,
  output logic [2:0]              AWSIZE,
  output logic [1:0]              AWBURST,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WLAST,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic [7:0]              ARLEN,
  output logic [2:0]              ARSIZE,
  output logic [1:0]              ARBURST,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RLAST,
  input  logic                    RVALID,
  output logic                    RREADY
);

  localparam logic [2:0] SIZE = size_from_width(DATA_WIDTH);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [8:0]            r_beat_cnt;
  logic                  r_err;
  logic                  r_done_valid;
  logic [1:0]            r_done_resp;

  logic        w_cmd_hs;
  logic        w_w_hs;
  logic        w_r_hs;
  logic        w_is_last;
  logic        w_all_loaded;
  logic        w_hold_en;
  logic        w_hold_valid;
  logic        w_cross;
  logic        w_b_err;
  logic        w_r_err;
  logic [8:0]  w_beats;
  logic [13:0] w_span_end;

  // Burst end offset within the 4 KB page; anything past 4096 crosses.
  assign w_beats    = {1'b0, cmd_len} + 9'd1;
  assign w_span_end = {2'b00, cmd_addr[11:0]} + ({5'd0, w_beats} << SIZE);
  assign w_cross    = w_span_end > 14'd4096;

  assign w_cmd_hs  = cmd_valid && cmd_ready;
  assign w_is_last = r_beat_cnt == {1'b0, r_len};
  assign w_w_hs    = w_hold_valid && WREADY;
  assign w_r_hs    = (r_state == ST_R) && RVALID && rd_data_ready;
  assign w_b_err   = r_err | (BRESP != RESP_OKAY);
  assign w_r_err   = r_err | (RRESP != RESP_OKAY) | (RLAST != w_is_last);

  // Beats sent plus the one parked in the hold register cover the whole burst.
  assign w_all_loaded = ({1'b0, r_beat_cnt} + {9'd0, w_hold_valid}) > {2'b00, r_len};

  axi4_w_hold #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_w_hold (
    .i_clk        (ACLK),
    .i_rst_n      (ARESETn),
    .i_enable     (w_hold_en),
    .i_data_valid (wr_data_valid),
    .o_data_ready (wr_data_ready),
    .i_data       (wr_data),
    .o_valid      (w_hold_valid),
    .o_data       (WDATA),
    .i_ready      (WREADY)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_cmd_hs) w_next = w_cross ? ST_ERR : (cmd_write ? ST_AW : ST_AR);
      ST_AW:   if (AWREADY) w_next = ST_W;
      ST_W:    if (w_w_hs && w_is_last) w_next = ST_B;
      ST_B:    if (BVALID) w_next = ST_IDLE;
      ST_AR:   if (ARREADY) w_next = ST_R;
      ST_R:    if (w_r_hs && w_is_last) w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready     = 1'b0;
    AWVALID       = 1'b0;
    ARVALID       = 1'b0;
    BREADY        = 1'b0;
    RREADY        = 1'b0;
    rd_data_valid = 1'b0;
    rd_last       = 1'b0;
    WLAST         = 1'b0;
    w_hold_en     = 1'b0;
    unique case (r_state)
      ST_IDLE: cmd_ready = !r_done_valid;
      ST_AW:   AWVALID = 1'b1;
      ST_W: begin
        w_hold_en = !w_all_loaded;
        WLAST     = w_is_last;
      end
      ST_B:    BREADY = 1'b1;
      ST_AR:   ARVALID = 1'b1;
      ST_R: begin
        RREADY        = rd_data_ready;
        rd_data_valid = RVALID;
        rd_last       = w_is_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_addr       <= '0;
      r_len        <= '0;
      r_beat_cnt   <= '0;
      r_err        <= 1'b0;
      r_done_valid <= 1'b0;
      r_done_resp  <= RESP_OKAY;
    end else begin
      r_done_valid <= 1'b0;
      unique case (r_state)
        ST_IDLE: if (w_cmd_hs) begin
          r_addr     <= cmd_addr;
          r_len      <= cmd_len;
          r_err      <= 1'b0;
          r_beat_cnt <= '0;
        end
        ST_W: if (w_w_hs) r_beat_cnt <= r_beat_cnt + 9'd1;
        ST_B: if (BVALID) begin
          r_err        <= w_b_err;
          r_done_valid <= 1'b1;
          r_done_resp  <= w_b_err ? RESP_SLVERR : RESP_OKAY;
        end
        ST_R: if (w_r_hs) begin
          r_beat_cnt <= r_beat_cnt + 9'd1;
          r_err      <= w_r_err;
          if (w_is_last) begin
            r_done_valid <= 1'b1;
            r_done_resp  <= w_r_err ? RESP_SLVERR : RESP_OKAY;
          end
        end
        ST_ERR: begin
          r_done_valid <= 1'b1;
          r_done_resp  <= RESP_SLVERR;
        end
        default: ;
      endcase
    end
  end

  assign busy       = r_state != ST_IDLE;
  assign done_valid = r_done_valid;
  assign done_resp  = r_done_resp;
  assign rd_data    = RDATA;

  assign AWADDR  = r_addr;
  assign AWLEN   = r_len;
  assign AWSIZE  = SIZE;
  assign AWBURST = BURST_INCR;
  assign WVALID  = w_hold_valid;
  assign WSTRB   = '1;
  assign ARADDR  = r_addr;
  assign ARLEN   = r_len;
  assign ARSIZE  = SIZE;
  assign ARBURST = BURST_INCR;

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master: writes, reads, 4 KB rejection, mid-burst reset.
module tb_axi4_burst_master;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wr_data_valid, wr_data_ready;
  logic [31:0] wr_data;
  logic        rd_data_valid, rd_data_ready;
  logic [31:0] rd_data;
  logic        rd_last, done_valid, busy;
  logic [1:0]  done_resp;
  logic [15:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST;
  logic        AWVALID, AWREADY, ARVALID, ARREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic [1:0]  BRESP, RRESP;
  logic        BVALID, BREADY, RLAST, RVALID, RREADY;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 ACLK = ~ACLK;

  axi4_burst_master #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(32)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data),
    .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready), .rd_data(rd_data),
    .rd_last(rd_last), .done_valid(done_valid), .done_resp(done_resp), .busy(busy),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge ACLK);
    #1;
  endtask

  // Starts and ends one time unit after a rising edge.
  task automatic do_write(input logic [15:0] a, input logic [7:0] l, input logic [31:0] base,
                          input bit stall, input logic [1:0] bresp, input logic [1:0] exp_resp);
    int unsigned p, q, cyc;
    logic [31:0] prev_d;
    bit          prev_stall;
    bit          wr_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = l;
    @(negedge ACLK);
    chk("wr_cmd_ready", cmd_ready, 1);
    next_cycle();
    cmd_valid = 1'b0;
    AWREADY = !stall;
    wr_data_valid = stall;
    wr_data = base;
    @(negedge ACLK);
    chk("awvalid", AWVALID, 1);
    chk("awaddr", AWADDR, a);
    chk("awlen", AWLEN, l);
    chk("awsize", AWSIZE, 3'd2);
    chk("awburst", AWBURST, 2'b01);
    chk("w_before_aw", WVALID, 0);
    chk("wr_ready_before_aw", wr_data_ready, 0);
    if (stall) begin
      next_cycle();
      AWREADY = 1'b1;
      @(negedge ACLK);
      chk("awvalid_hold", AWVALID, 1);
      chk("awaddr_hold", AWADDR, a);
      chk("w_before_aw2", WVALID, 0);
    end
    next_cycle();
    AWREADY = 1'b0;
    p = 0; q = 0; cyc = 0; prev_stall = 1'b0; prev_d = '0;
    while (q <= l && cyc < 200) begin
      WREADY = stall ? wr_pat[cyc % 4] : 1'b1;
      wr_data_valid = (p <= l) && !(stall && (cyc % 5 == 2));
      wr_data = base + p;
      @(negedge ACLK);
      chk("awvalid_in_w", AWVALID, 0);
      if (prev_stall) begin
        chk("wvalid_stable", WVALID, 1);
        chk("wdata_stable", WDATA, prev_d);
      end
      if (p > l) chk("no_extra_ready", wr_data_ready, 0);
      if (WVALID && WREADY) begin
        chk("wdata", WDATA, base + q);
        chk("wlast", WLAST, q == l);
        chk("wstrb", WSTRB, 4'hF);
        q++;
      end else begin
        chk("wlast_early", WLAST && (q != l), 0);
      end
      prev_stall = WVALID && !WREADY;
      prev_d = WDATA;
      if (wr_data_valid && wr_data_ready) p++;
      next_cycle();
      cyc++;
    end
    chk("w_beats", q, l + 1);
    WREADY = 1'b0; wr_data_valid = 1'b0;
    BVALID = 1'b1; BRESP = bresp;
    @(negedge ACLK);
    chk("bready", BREADY, 1);
    chk("b_busy", busy, 1);
    chk("b_wvalid", WVALID, 0);
    chk("b_no_done", done_valid, 0);
    next_cycle();
    BVALID = 1'b0; BRESP = 2'b00;
    @(negedge ACLK);
    chk("wr_done_valid", done_valid, 1);
    chk("wr_done_resp", done_resp, exp_resp);
    chk("wr_done_busy", busy, 0);
    chk("wr_done_cmd_ready", cmd_ready, 0);
    next_cycle();
    @(negedge ACLK);
    chk("wr_done_pulse", done_valid, 0);
    chk("wr_cmd_ready_again", cmd_ready, 1);
    next_cycle();
  endtask

  task automatic do_read(input logic [15:0] a, input logic [7:0] l, input logic [31:0] base,
                         input bit throttle, input int early, input int err_beat,
                         input logic [1:0] exp_resp);
    int k, cyc;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = l;
    @(negedge ACLK);
    chk("rd_cmd_ready", cmd_ready, 1);
    next_cycle();
    cmd_valid = 1'b0;
    ARREADY = 1'b1;
    @(negedge ACLK);
    chk("arvalid", ARVALID, 1);
    chk("araddr", ARADDR, a);
    chk("arlen", ARLEN, l);
    chk("arsize", ARSIZE, 3'd2);
    chk("arburst", ARBURST, 2'b01);
    chk("ar_awvalid", AWVALID, 0);
    chk("ar_rready", RREADY, 0);
    next_cycle();
    ARREADY = 1'b0;
    k = 0; cyc = 0;
    while (k <= int'(l) && cyc < 100) begin
      RVALID = 1'b1;
      RDATA  = base + k;
      RRESP  = (k == err_beat) ? 2'b10 : 2'b00;
      RLAST  = (early >= 0) ? (k == early) : (k == int'(l));
      rd_data_ready = throttle ? (cyc % 2 == 0) : 1'b1;
      @(negedge ACLK);
      chk("rd_valid", rd_data_valid, 1);
      chk("rd_data", rd_data, base + k);
      chk("rd_last", rd_last, k == int'(l));
      chk("rready", RREADY, rd_data_ready);
      chk("rd_no_done", done_valid, 0);
      if (rd_data_ready) k++;
      next_cycle();
      cyc++;
    end
    chk("rd_beats", k, l + 1);
    RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; rd_data_ready = 1'b0;
    @(negedge ACLK);
    chk("rd_done_valid", done_valid, 1);
    chk("rd_done_resp", done_resp, exp_resp);
    chk("rd_done_busy", busy, 0);
    chk("rd_done_cmd_ready", cmd_ready, 0);
    chk("rd_done_rvalid", rd_data_valid, 0);
    next_cycle();
    @(negedge ACLK);
    chk("rd_done_pulse", done_valid, 0);
    next_cycle();
  endtask

  initial begin
    ARESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data_valid = 1'b0; wr_data = '0; rd_data_ready = 1'b0;
    AWREADY = 1'b0; WREADY = 1'b0; BRESP = 2'b00; BVALID = 1'b0;
    ARREADY = 1'b0; RDATA = '0; RRESP = 2'b00; RLAST = 1'b0; RVALID = 1'b0;

    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_busy", busy, 0);
    chk("rst_awvalid", AWVALID, 0);
    chk("rst_wvalid", WVALID, 0);
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_bready", BREADY, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_resp", done_resp, 2'b00);
    chk("rst_awaddr", AWADDR, 16'h0000);
    chk("rst_awlen", AWLEN, 8'h00);
    chk("rst_wdata", WDATA, 32'h0);
    next_cycle();
    ARESETn = 1'b1;
    next_cycle();

    do_write(16'h0100, 8'd3, 32'hA0, 1'b0, 2'b00, 2'b00);
    do_write(16'h0100, 8'd3, 32'hA0, 1'b1, 2'b00, 2'b00);
    // Exactly reaches the page end (no crossing); BRESP=01 counts as an error.
    do_write(16'h0FF0, 8'd3, 32'h50, 1'b0, 2'b01, 2'b10);
    do_read(16'h0200, 8'd0, 32'h1000, 1'b0, -1, 0, 2'b10);
    do_read(16'h0300, 8'd7, 32'h2000, 1'b1, 5, -1, 2'b10);
    do_read(16'h0400, 8'd2, 32'h3000, 1'b0, -1, -1, 2'b00);

    // 4 KB crossing: 0xFF8 + 4*4 = 0x1008.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0FF8; cmd_len = 8'd3;
    @(negedge ACLK);
    chk("err_cmd_ready", cmd_ready, 1);
    next_cycle();
    cmd_valid = 1'b0; AWREADY = 1'b1;
    @(negedge ACLK);
    chk("err_awvalid", AWVALID, 0);
    chk("err_busy", busy, 1);
    chk("err_no_done_yet", done_valid, 0);
    next_cycle();
    @(negedge ACLK);
    chk("err_done_valid", done_valid, 1);
    chk("err_done_resp", done_resp, 2'b10);
    chk("err_awvalid2", AWVALID, 0);
    next_cycle();
    AWREADY = 1'b0;
    @(negedge ACLK);
    chk("err_done_pulse", done_valid, 0);
    next_cycle();

    // Reset while the second beat is on the W channel.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0500; cmd_len = 8'd3;
    next_cycle();
    cmd_valid = 1'b0; AWREADY = 1'b1;
    next_cycle();
    AWREADY = 1'b0; WREADY = 1'b1; wr_data_valid = 1'b1; wr_data = 32'hB0;
    next_cycle();
    wr_data = 32'hB1;
    next_cycle();
    chk("mid_wvalid", WVALID, 1);
    chk("mid_wdata", WDATA, 32'hB1);
    ARESETn = 1'b0;
    #1;
    chk("mid_rst_wvalid", WVALID, 0);
    chk("mid_rst_awvalid", AWVALID, 0);
    chk("mid_rst_arvalid", ARVALID, 0);
    chk("mid_rst_bready", BREADY, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done_valid, 0);
    WREADY = 1'b0; wr_data_valid = 1'b0;
    next_cycle();
    next_cycle();
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("post_rst_done", done_valid, 0);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    next_cycle();
    do_write(16'h0600, 8'd3, 32'hD0, 1'b0, 2'b00, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
